// File: rtl/inst_axi_reader_pkg.sv
// ============================================================================
// Module      : inst_axi_reader_pkg
// Description : Shared constants for the instruction-side AXI read master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_axi_reader_pkg;

    localparam logic        RST_ENABLE  = 1'b1;
    localparam int          INST_ADDR_W = 32;
    localparam int          INST_W      = 32;
    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
    localparam logic        VALID       = 1'b1;
    localparam logic        INVALID     = 1'b0;
    localparam logic        READY       = 1'b1;
    localparam logic        NOT_READY   = 1'b0;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam logic [2:0]  SIZE_4B     = 3'b010;

endpackage

`default_nettype wire

// File: rtl/inst_axi_reader_last_buf.sv
// ============================================================================
// Module      : inst_last_buf
// Description : One-entry last-fetch buffer; only instantiated when
//               INST_LAST_HIT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_last_buf
    import inst_axi_reader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        clr,
    input  logic [29:0] wr_pc,
    input  logic [31:0] wr_inst,
    input  logic [29:0] lookup_pc,
    output logic        hit,
    output logic [31:0] hit_inst
);

    logic        r_tag_valid;
    logic [29:0] r_tag_pc;
    logic [31:0] r_tag_inst;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_tag_valid <= 1'b0;
            r_tag_pc    <= '0;
            r_tag_inst  <= ZERO_WORD;
        end else if (clr) begin
            r_tag_valid <= 1'b0;
        end else if (wr_en) begin
            r_tag_valid <= 1'b1;
            r_tag_pc    <= wr_pc;
            r_tag_inst  <= wr_inst;
        end
    end

    assign hit      = r_tag_valid && (lookup_pc == r_tag_pc);
    assign hit_inst = r_tag_inst;

endmodule

`default_nettype wire

// File: rtl/inst_axi_reader.sv
// ============================================================================
// Module      : inst_axi_reader
// Description : Single-beat AXI4 instruction fetch master feeding IF/ID.
//               Optional last-fetch hit buffer: define INST_LAST_HIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_axi_reader
    import inst_axi_reader_pkg::*;
#(
    parameter int          ID_W     = 4,
    parameter int unsigned ARID_VAL = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INST_ADDR_W-1:0] if_pc,
    input  logic                   fetch_req,
    input  logic                   flush,
    input  logic                   inst_ready,
    output logic                   inst_valid,
    output logic [INST_W-1:0]      inst,
    output logic [INST_ADDR_W-1:0] inst_pc,
    output logic                   inst_err,
    output logic                   fetch_busy,
    output logic [ID_W-1:0]        arid,
    output logic [INST_ADDR_W-1:0] araddr,
    output logic [7:0]             arlen,
    output logic [2:0]             arsize,
    output logic [1:0]             arburst,
    output logic                   arvalid,
    input  logic                   arready,
    input  logic [ID_W-1:0]        rid,
    input  logic [INST_W-1:0]      rdata,
    input  logic [1:0]             rresp,
    input  logic                   rlast,
    input  logic                   rvalid,
    output logic                   rready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t                   r_state,      w_state_nxt;
    logic                     r_arvalid,    w_arvalid_nxt;
    logic                     r_rready,     w_rready_nxt;
    logic                     r_inst_valid, w_inst_valid_nxt;
    logic [INST_W-1:0]        r_inst,       w_inst_nxt;
    logic [INST_ADDR_W-1:0]   r_inst_pc,    w_inst_pc_nxt;
    logic                     r_inst_err,   w_inst_err_nxt;
    logic [INST_ADDR_W-1:0]   r_araddr,     w_araddr_nxt;
    logic                     r_discard,    w_discard_nxt;

    logic                     w_hit;
    logic [INST_W-1:0]        w_hit_inst;
    logic                     w_buf_wr;
    logic                     w_buf_clr;
    logic                     w_rid_ok;
    logic [INST_ADDR_W-1:0]   w_new_addr;
    logic                     w_unused;

    assign w_rid_ok   = (rid == ID_W'(ARID_VAL));
    assign w_new_addr = {if_pc[31:2], 2'b00};

`ifdef INST_LAST_HIT_EN
    inst_last_buf u_last_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (w_buf_wr),
        .clr       (w_buf_clr),
        .wr_pc     (r_araddr[31:2]),
        .wr_inst   (rdata),
        .lookup_pc (if_pc[31:2]),
        .hit       (w_hit),
        .hit_inst  (w_hit_inst)
    );
    assign w_unused = ^{rlast, if_pc[1:0], r_araddr[1:0]};
`else
    assign w_hit      = 1'b0;
    assign w_hit_inst = ZERO_WORD;
    assign w_unused   = ^{rlast, if_pc[1:0], w_buf_wr, w_buf_clr};
`endif

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_state      <= S_IDLE;
            r_arvalid    <= 1'b0;
            r_rready     <= NOT_READY;
            r_inst_valid <= INVALID;
            r_inst       <= ZERO_WORD;
            r_inst_pc    <= ZERO_WORD;
            r_inst_err   <= 1'b0;
            r_araddr     <= ZERO_WORD;
            r_discard    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_arvalid    <= w_arvalid_nxt;
            r_rready     <= w_rready_nxt;
            r_inst_valid <= w_inst_valid_nxt;
            r_inst       <= w_inst_nxt;
            r_inst_pc    <= w_inst_pc_nxt;
            r_inst_err   <= w_inst_err_nxt;
            r_araddr     <= w_araddr_nxt;
            r_discard    <= w_discard_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_arvalid_nxt    = r_arvalid;
        w_rready_nxt     = r_rready;
        w_inst_valid_nxt = r_inst_valid;
        w_inst_nxt       = r_inst;
        w_inst_pc_nxt    = r_inst_pc;
        w_inst_err_nxt   = r_inst_err;
        w_araddr_nxt     = r_araddr;
        w_discard_nxt    = r_discard;
        w_buf_wr         = 1'b0;
        w_buf_clr        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (fetch_req && !flush) begin
                    if (w_hit) begin
                        w_state_nxt      = S_HOLD;
                        w_inst_valid_nxt = VALID;
                        w_inst_nxt       = w_hit_inst;
                        w_inst_pc_nxt    = w_new_addr;
                        w_inst_err_nxt   = 1'b0;
                    end else begin
                        w_state_nxt   = S_AR;
                        w_araddr_nxt  = w_new_addr;
                        w_arvalid_nxt = 1'b1;
                    end
                end
            end
            S_AR: begin
                // arvalid must not drop on flush; the response is drained instead
                if (flush) w_discard_nxt = 1'b1;
                if (r_arvalid && arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = READY;
                    w_state_nxt   = S_R;
                end
            end
            S_R: begin
                if (flush) w_discard_nxt = 1'b1;
                if (rvalid && r_rready && w_rid_ok) begin
                    w_rready_nxt  = NOT_READY;
                    w_inst_pc_nxt = r_araddr;
                    w_buf_clr     = (rresp != RESP_OKAY);
                    // a flush coinciding with the beat also makes it stale
                    if (r_discard || flush) begin
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = S_IDLE;
                    end else begin
                        w_buf_wr         = (rresp == RESP_OKAY);
                        w_inst_nxt       = (rresp == RESP_OKAY) ? rdata : ZERO_WORD;
                        w_inst_err_nxt   = (rresp != RESP_OKAY);
                        w_inst_valid_nxt = VALID;
                        w_state_nxt      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (flush) begin
                    w_inst_valid_nxt = INVALID;
                    w_state_nxt      = S_IDLE;
                end else if (inst_ready) begin
                    w_inst_valid_nxt = INVALID;
                    w_state_nxt      = S_IDLE;
                    if (fetch_req) begin
                        if (w_hit) begin
                            w_state_nxt      = S_HOLD;
                            w_inst_valid_nxt = VALID;
                            w_inst_nxt       = w_hit_inst;
                            w_inst_pc_nxt    = w_new_addr;
                            w_inst_err_nxt   = 1'b0;
                        end else begin
                            w_state_nxt   = S_AR;
                            w_araddr_nxt  = w_new_addr;
                            w_arvalid_nxt = 1'b1;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inst_err   = r_inst_err;
    assign fetch_busy = (r_state == S_AR) || (r_state == S_R);
    assign arid       = ID_W'(ARID_VAL);
    assign araddr     = r_araddr;
    assign arlen      = 8'd0;
    assign arsize     = SIZE_4B;
    assign arburst    = BURST_INCR;
    assign arvalid    = r_arvalid;
    assign rready     = r_rready;

endmodule

`default_nettype wire

// File: doc/inst_axi_reader.md
Name: inst_axi_reader

Overview:
- Instruction-side AXI4 read master; the producing end of the inst_valid / inst_ready handshake consumed by the IF/ID pipeline register.
- Accepts a fetch request for the current PC, issues one single-beat AXI read, and presents the returned word with inst_valid until inst_ready accepts it.
- Sits between the PC/IF stage and the AXI interconnect. Handles flush by discarding in-flight data, since AXI cannot cancel a transaction.

Parameters:
- ID_W, 4, width of arid/rid.
- ARID_VAL, 0, ID driven on arid; R beats with a different rid are ignored.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high (RstEnable = 1)
- if_pc  in  32  fetch address from IF stage
- fetch_req  in  1  IF requests the instruction at if_pc
- flush  in  1  pipeline flush from CTRL
- inst_ready  in  1  IF/ID can take the instruction this cycle
- inst_valid  out  1  inst/inst_pc hold a fetched instruction
- inst  out  32  fetched instruction
- inst_pc  out  32  address of inst
- inst_err  out  1  qualifies inst_valid: bus error, inst forced to ZeroWord
- fetch_busy  out  1  transaction outstanding (state AR, R or DRAIN)
- arid  out  ID_W  constant ARID_VAL
- araddr  out  32  read address, low 2 bits forced 0
- arlen / arsize / arburst  out  8/3/2  constants 0 / 3'b010 / 2'b01
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  ID_W  R id
- rdata  in  32  R data
- rresp  in  2  R response
- rlast  in  1  R last (expected 1)
- rvalid  in  1  R valid
- rready  out  1  R ready

Behaviour:
- Reset: state IDLE; arvalid, rready, inst_valid, inst_err, fetch_busy = 0; inst, inst_pc, araddr = ZeroWord; discard = 0.
- IDLE: when fetch_req && !flush, latch araddr = {if_pc[31:2], 2'b00} and set arvalid = 1; next state AR.
- AR:
  - arvalid and araddr stay stable until arready (AXI rule; flush never drops arvalid).
  - On arvalid && arready: arvalid = 0, rready = 1; next state R.
- R: on rvalid && rready && rid == ARID_VAL: rready = 0, inst_pc = araddr.
  - If discard: clear discard and go to IDLE with no inst_valid.
  - Else: inst = rdata, or ZeroWord with inst_err = 1 when rresp != 2'b00; set inst_valid = 1; go to HOLD.
- HOLD: inst, inst_pc and inst_err are stable while inst_valid = 1.
  - inst_ready = 1: inst_valid = 0. If fetch_req is also high, latch the new araddr and go straight to AR (back-to-back); otherwise go to IDLE.
  - flush = 1: inst_valid = 0; next state IDLE. Flush has priority over inst_ready.
- Flush in AR or R sets discard = 1; the beat is still received and dropped (DRAIN is R with discard set). Flush in IDLE has no effect.
- Minimum latency: arready in cycle n, rvalid in cycle n+1, inst_valid in cycle n+2. From fetch_req to arvalid is 1 cycle.
- One outstanding transaction at most. fetch_req is ignored while fetch_busy.
- Reset mid-transaction returns to IDLE immediately. The slave shares rst, so no stale beat is expected.
- R beats with a mismatched rid, or received outside state R, are ignored; rready stays low outside R.

Optional Feature:
- Macro: INST_LAST_HIT_EN
- With the macro: a one-entry {tag_valid, tag_pc, tag_inst} buffer is written on every error-free, non-discarded R capture.
  - In IDLE, or in HOLD on accept, if fetch_req && tag_valid && if_pc[31:2] == tag_pc[31:2], go to HOLD next cycle with inst = tag_inst and no AXI traffic.
  - tag_valid is cleared by rst and by any error response.
- Without the macro: every fetch issues an AXI read; no buffer registers exist.

Decomposition:
- defines.v holds: RstEnable, ZeroWord, Valid/InValid, Ready/NotReady, InstAddrBus/InstBus widths, AXI constants (RESP_OKAY 2'b00, BURST_INCR 2'b01, SIZE_4B 3'b010).
- State encoding is local to the module.
- Optional sub-module inst_last_buf holds the hit buffer under INST_LAST_HIT_EN.

Test Plan:
- Basic fetch: if_pc = 0xBFC00000, fetch_req = 1, arready after 2 cycles, rdata = 0x3C011234 one cycle later -> araddr = 0xBFC00000; inst_valid high with inst = 0x3C011234, inst_pc = 0xBFC00000; held 3 cycles until inst_ready = 1, then low.
- Flush during R: flush pulses 1 cycle after the AR handshake, rdata = 0xDEADBEEF -> beat accepted (rready = 1), inst_valid never asserts, state IDLE; next fetch of 0xBFC00004 returns its own data.
- Error response: rresp = 2'b10 -> inst_valid = 1, inst = 0x00000000, inst_err = 1.
- Back-to-back: inst_ready and fetch_req (if_pc = 0xBFC00008) together in HOLD -> arvalid rises the next cycle with araddr = 0xBFC00008, no IDLE cycle.
- Reset mid-AR: rst while arvalid = 1 -> next cycle arvalid = 0, all outputs at reset values.
- INST_LAST_HIT_EN: refetch of 0xBFC00000 after a clean fetch -> inst_valid one cycle after fetch_req, arvalid stays 0.
